// File: rtl/matrix_key_scanner_if.sv
// matrix_key_scanner_if: key-event stream from the scanner's event FIFO to
// its consumer. The scanner drives the master side, the key decoder the slave.
interface matrix_key_scanner_if #(
  parameter int CW = 4
);
  logic          ev_valid;
  logic [CW-1:0] ev_code;
  logic          ev_rel;
  logic          ev_ready;

  modport master (output ev_valid, ev_code, ev_rel, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_rel, output ev_ready);
endinterface

// File: rtl/matrix_key_scanner.sv
// matrix_key_scanner: ROWS x COLS key-matrix scanner.
// - One-cold column strobe on even scan steps, active-low row sample on odd
//   steps; one step per tick, 2*COLS steps per frame.
// - Frame-level debounce: key map follows a frame only after DEB_FRAMES
//   consecutive identical frames.
// - Each key-map update queues at most one event (lowest pressed index) into
//   a FIFO with a sticky overflow flag.
// Optional feature macro: MATRIX_KEY_RELEASE_EN adds release events (lowest
// released index, only when nothing new was pressed); without it ev_rel is 0.
module matrix_key_scanner #(
  parameter  int ROWS       = 4,
  parameter  int COLS       = 4,
  parameter  int DEB_FRAMES = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int N          = ROWS * COLS,
  localparam int CW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [N-1:0]    key,
  output logic            tc,
  output logic            ovf,
  matrix_key_scanner_if.master evq
);

  localparam int            IW       = $clog2(2 * COLS);
  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(2 * COLS - 1);

  typedef struct packed {
    logic          rel;
    logic [CW-1:0] code;
  } ev_t;

  // lowest set bit index of a key mask (0 when empty, callers gate on |m)
  function automatic logic [CW-1:0] lowest(input logic [N-1:0] m);
    logic [CW-1:0] l;
    l = '0;
    for (int i = N - 1; i >= 0; i--)
      if (m[i]) l = CW'(i);
    return l;
  endfunction

  // ---------------------------------------------------------------- scan
  logic [IW-1:0] idx;
  logic [IW-1:0] cidx;
  logic [N-1:0]  raw;
  logic [N-1:0]  raw_nxt;
  logic [N-1:0]  frm;
  logic          scan_end;

  assign cidx     = idx >> 1;
  assign scan_end = tick && (idx == IDX_LAST);

  // raw map with the column being sampled this step merged in, so the last
  // column of a frame lands in frm on the same edge
  always_comb begin
    raw_nxt = raw;
    if (tick && idx[0])
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (cidx == IW'(c)) raw_nxt[r*COLS+c] = ~row[r];
  end

  // step counter, column strobe, raw sampling and frame capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
      col <= '1;
      raw <= '0;
      frm <= '0;
      tc  <= 1'b0;
    end else begin
      tc <= scan_end;
      if (tick) begin
        raw <= raw_nxt;
        idx <= scan_end ? '0 : idx + IW'(1);
        if (!idx[0]) col <= ~(COLS'(1) << cidx);
        if (scan_end) frm <= raw_nxt;
      end
    end
  end

  // ------------------------------------------------------------ debounce
  logic [N-1:0] prev;
  logic [3:0]   cnt;
  logic [3:0]   cnt_nxt;
  logic         upd;
  logic [N-1:0] pmask;
  logic         ev_req;
  ev_t          ev_new;
  logic         push;
  ev_t          push_ev;

  assign cnt_nxt = (frm != prev)   ? 4'd1 :
                   (cnt == 4'd15)  ? cnt  : cnt + 4'd1;
  assign upd     = tc && (cnt_nxt >= 4'(DEB_FRAMES)) && (frm != key);
  assign pmask   = frm & ~key;

`ifdef MATRIX_KEY_RELEASE_EN
  logic [N-1:0] rmask;
  assign rmask = key & ~frm;
`endif

  // pick the single event an update produces; a press beats a release
  always_comb begin
    ev_req = 1'b0;
    ev_new = '0;
    if (|pmask) begin
      ev_req      = 1'b1;
      ev_new.code = lowest(pmask);
    end
`ifdef MATRIX_KEY_RELEASE_EN
    else if (|rmask) begin
      ev_req      = 1'b1;
      ev_new.rel  = 1'b1;
      ev_new.code = lowest(rmask);
    end
`endif
  end

  // debounce counter, key map, and the registered push toward the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev    <= '0;
      cnt     <= '0;
      key     <= '0;
      push    <= 1'b0;
      push_ev <= '0;
    end else begin
      push    <= upd && ev_req;
      push_ev <= ev_new;
      if (tc) begin
        cnt  <= cnt_nxt;
        prev <= frm;
      end
      if (upd) key <= frm;
    end
  end

  // ---------------------------------------------------------------- fifo
  logic [AW:0] wp;
  logic [AW:0] rp;
  ev_t         mem [FIFO_DEPTH];
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = !empty && evq.ev_ready;
  // when full, a same-cycle pop frees the slot being written
  assign wr    = push && (!full || pop);

  // event storage, pointers and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      ovf <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp[AW-1:0]] <= push_ev;
        wp              <= wp + (AW+1)'(1);
      end
      if (pop) rp <= rp + (AW+1)'(1);
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  assign evq.ev_valid = !empty;
  assign evq.ev_code  = mem[rp[AW-1:0]].code;
`ifdef MATRIX_KEY_RELEASE_EN
  assign evq.ev_rel   = mem[rp[AW-1:0]].rel;
`else
  assign evq.ev_rel   = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_key_scanner.sv
// tb_matrix_key_scanner: directed + randomized bench for matrix_key_scanner.
// A physical key matrix drives the rows from the strobed column; a frame-level
// model (debounce count, key map, event queue) predicts key, FIFO and ovf.
module tb_matrix_key_scanner;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DEB  = 2;
  localparam int DEP  = 4;
  localparam int N    = ROWS * COLS;
  localparam int CW   = $clog2(N);
`ifdef MATRIX_KEY_RELEASE_EN
  localparam bit REL  = 1'b1;
`else
  localparam bit REL  = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            tick;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic [N-1:0]    key;
  logic            tc;
  logic            ovf;
  logic [N-1:0]    pressed;

  int checks   = 0;
  int failures = 0;

  matrix_key_scanner_if #(.CW(CW)) evq();

  matrix_key_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DEB_FRAMES(DEB), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .row(row), .col(col),
    .key(key), .tc(tc), .ovf(ovf), .evq(evq)
  );

  always #5 clk = ~clk;

  // key matrix: a pressed key pulls its row low while its column is strobed
  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!col[c] && pressed[r*COLS+c]) row[r] = 1'b0;
  end

  // ---------------------------------------------------------------- model
  typedef struct { int code; bit rel; } mev_t;
  mev_t         q[$];
  logic [N-1:0] m_key;
  logic [N-1:0] m_prev;
  int           m_cnt;
  bit           m_ovf;

  task automatic model_reset();
    m_key = '0; m_prev = '0; m_cnt = 0; m_ovf = 1'b0;
    q.delete();
  endtask

  function automatic int low_idx(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic model_push(input int code, input bit rel);
    mev_t e;
    e.code = code; e.rel = rel;
    if (q.size() == DEP) m_ovf = 1'b1;
    else q.push_back(e);
  endtask

  task automatic model_frame(input logic [N-1:0] v);
    logic [N-1:0] pm, rm;
    m_cnt  = (v == m_prev) ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 1;
    m_prev = v;
    if (m_cnt >= DEB && v != m_key) begin
      pm = v & ~m_key;
      rm = m_key & ~v;
      if (pm != 0) model_push(low_idx(pm), 1'b0);
      else if (REL && rm != 0) model_push(low_idx(rm), 1'b1);
      m_key = v;
    end
  endtask

  // ------------------------------------------------------------- checking
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fifo(input string tag);
    chk({tag, "_valid"}, 32'(evq.ev_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, "_code"}, 32'(evq.ev_code), 32'(q[0].code));
      chk({tag, "_rel"},  32'(evq.ev_rel),  32'(q[0].rel));
    end
    chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
  endtask

  // one frame of 2*COLS ticks with the matrix held at p; checks strobes, tc,
  // then key (cycle after tc) and FIFO head (one cycle later)
  task automatic run_frame(input logic [N-1:0] p, input bit fast);
    pressed = p;
    for (int t = 0; t < 2 * COLS; t++) begin
      if (!fast) begin tick = 1'b0; @(negedge clk); end
      tick = 1'b1;
      @(negedge clk);
      if (t % 2 == 0) chk("col", 32'(col), 32'(~(COLS'(1) << (t / 2)) & {COLS{1'b1}}));
      chk("tc", 32'(tc), 32'(t == 2 * COLS - 1));
    end
    tick = 1'b0;
    model_frame(p);
    @(negedge clk);
    chk("key", 32'(key), 32'(m_key));
    chk("tc_low", 32'(tc), 32'd0);
    @(negedge clk);
    check_fifo("frame");
  endtask

  task automatic run_ticks(input int n);
    for (int t = 0; t < n; t++) begin
      tick = 1'b0; @(negedge clk);
      tick = 1'b1; @(negedge clk);
    end
    tick = 1'b0;
  endtask

  // pop the head: checks it stays put while not accepted, then accepts it
  task automatic pop_one();
    mev_t h;
    if (q.size() == 0) return;
    h = q[0];
    chk("head_valid", 32'(evq.ev_valid), 32'd1);
    @(negedge clk);
    chk("hold_code", 32'(evq.ev_code), 32'(h.code));
    chk("hold_rel",  32'(evq.ev_rel),  32'(h.rel));
    evq.ev_ready = 1'b1;
    @(negedge clk);
    evq.ev_ready = 1'b0;
    void'(q.pop_front());
    check_fifo("pop");
  endtask

  task automatic drain();
    while (q.size() != 0) pop_one();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_col"},   32'(col), 32'hF);
    chk({tag, "_key"},   32'(key), 32'd0);
    chk({tag, "_tc"},    32'(tc), 32'd0);
    chk({tag, "_valid"}, 32'(evq.ev_valid), 32'd0);
    chk({tag, "_code"},  32'(evq.ev_code), 32'd0);
    chk({tag, "_rel"},   32'(evq.ev_rel), 32'd0);
    chk({tag, "_ovf"},   32'(ovf), 32'd0);
  endtask

  logic [N-1:0] pk;
  int           codes [5] = '{0, 5, 10, 15, 3};

  initial begin
    // reset with tick asserted: must be ignored
    rst = 1'b0; tick = 1'b1; pressed = '0; evq.ev_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    tick = 1'b0; rst = 1'b1;

    // idle frames: strobe sequence, tc cadence, nothing reported
    run_frame('0, 1'b0);
    run_frame('0, 1'b1);

    // row 1, column 2 -> code 6, visible after the 2nd frame
    run_frame(16'h0040, 1'b0);
    chk("key6_early", 32'(key), 32'd0);
    run_frame(16'h0040, 1'b0);
    chk("key6", 32'(key), 32'h0040);
    chk("key6_code", 32'(evq.ev_code), 32'd6);
    pop_one();
    run_frame('0, 1'b0);
    run_frame('0, 1'b0);
    drain();

    // bounce: present, absent, present, present -> one event after frame 4
    run_frame(16'h0200, 1'b0);
    run_frame('0, 1'b0);
    run_frame(16'h0200, 1'b0);
    chk("bounce_early", 32'(key), 32'd0);
    run_frame(16'h0200, 1'b1);
    chk("bounce_key", 32'(key), 32'h0200);
    pop_one();
    chk("bounce_one", 32'(evq.ev_valid), 32'd0);
    run_frame('0, 1'b0);
    run_frame('0, 1'b0);
    drain();

    // press then release key 3
    run_frame(16'h0008, 1'b0);
    run_frame(16'h0008, 1'b0);
    chk("k3_code", 32'(evq.ev_code), 32'd3);
    pop_one();
    run_frame('0, 1'b0);
    run_frame('0, 1'b0);
    chk("k3_rel_valid", 32'(evq.ev_valid), 32'(REL));
    if (REL) chk("k3_rel", 32'(evq.ev_rel), 32'd1);
    drain();

    // random matrix activity with occasional pops
    for (int it = 0; it < 20; it++) begin
      case ($urandom % 4)
        0:       pk = '0;
        3:       pk = N'($urandom);
        default: begin pk = '0; pk[$urandom_range(0, N - 1)] = 1'b1; end
      endcase
      for (int f = 0; f < int'($urandom_range(1, 3)); f++)
        run_frame(pk, 1'($urandom % 2));
      if (q.size() != 0 && ($urandom % 2) == 1) pop_one();
    end
    run_frame('0, 1'b0);
    run_frame('0, 1'b0);
    drain();

    // overflow: five presses with no consumer, FIFO of four
    foreach (codes[i]) begin
      pk = '0; pk[codes[i]] = 1'b1;
      run_frame(pk, 1'b0);
      run_frame(pk, 1'b1);
      run_frame('0, 1'b0);
      run_frame('0, 1'b1);
    end
    chk("ovf_set", 32'(ovf), 32'(m_ovf));
    drain();

    // reset at idx=5 with key 9 held and an event pending
    run_frame(16'h0200, 1'b0);
    run_frame(16'h0200, 1'b0);
    run_ticks(5);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    run_frame(16'h0200, 1'b0);
    chk("midrst_f1", 32'(key), 32'd0);
    run_frame(16'h0200, 1'b0);
    chk("midrst_f2", 32'(key), 32'h0200);
    pop_one();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
